// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and constants for the write-through data-cache
// controller.
//   - DCACHE_WORD_BYTES : bytes per array word (one line == one word)
//   - DCACHE_S_*        : FSM state encodings as plain constants, so that
//                         legacy code and checkers can match raw state values
//   - dcache_state_e    : controller FSM state, encoded from the constants above
//   - mem_req_t         : one memory-port request (we, addr, wdata, wstrb)
package dcache_pkg;

  localparam int DCACHE_WORD_BYTES = 4;

  localparam logic [2:0] DCACHE_S_IDLE      = 3'd0;
  localparam logic [2:0] DCACHE_S_LOOKUP    = 3'd1;
  localparam logic [2:0] DCACHE_S_MISS_REQ  = 3'd2;
  localparam logic [2:0] DCACHE_S_MISS_WAIT = 3'd3;
  localparam logic [2:0] DCACHE_S_WR_REQ    = 3'd4;
  localparam logic [2:0] DCACHE_S_WR_WAIT   = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE      = DCACHE_S_IDLE,
    ST_LOOKUP    = DCACHE_S_LOOKUP,
    ST_MISS_REQ  = DCACHE_S_MISS_REQ,
    ST_MISS_WAIT = DCACHE_S_MISS_WAIT,
    ST_WR_REQ    = DCACHE_S_WR_REQ,
    ST_WR_WAIT   = DCACHE_S_WR_WAIT
  } dcache_state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_req_t;

endpackage

// File: rtl/dcache_perf.sv
// dcache_perf: lookup statistics for the data-cache controller.
// Ports:
//   clk, rst    : clock and synchronous active-high reset (clears both counters)
//   lookup      : a tag lookup is being resolved this cycle
//   hit         : outcome of that lookup
//   hit_count   : number of lookups that hit, wraps modulo 2^PERF_WIDTH
//   miss_count  : number of lookups that missed, wraps modulo 2^PERF_WIDTH
module dcache_perf
  import dcache_pkg::*;
#(
  parameter int PERF_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lookup,
  input  logic                  hit,
  output logic [PERF_WIDTH-1:0] hit_count,
  output logic [PERF_WIDTH-1:0] miss_count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (lookup) begin
      if (hit) hit_count <= hit_count + PERF_WIDTH'(1);
      else     miss_count <= miss_count + PERF_WIDTH'(1);
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: write-through, no-write-allocate controller in front of a
// direct-mapped tag/data array. One request in flight at a time.
//
// Build option: define DCACHE_PERF_EN to include the hit/miss counters;
// without it both perf ports are tied to 0.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   req_*               : LSU request (valid/ready), addr, we, wdata, wstrb
//   resp_valid/rdata    : one-cycle completion pulse; rdata is 0 on stores
//   cache_addr          : array address (req_addr in IDLE, latched addr after)
//   cache_hit/rdata     : array lookup result, one cycle after cache_addr
//   cache_wdata/write_* : array write port; write_access (dirty) is always 0
//   mem_req_*           : memory request (valid/ready), we, addr, wdata, wstrb
//   mem_resp_*          : memory read data / store acknowledge
//   perf_*_count        : lookup hit/miss statistics
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. Once mem_req_valid is raised it stays high with every mem_req_*
// field unchanged until that edge (the fields come only from latched request
// registers). req_ready is 1 only in IDLE, so a request is taken on the edge
// where req_valid is 1 in IDLE.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int LINE_SIZE  = 4,
  parameter int PERF_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  input  logic                  req_we,
  input  logic [31:0]           req_wdata,
  input  logic [3:0]            req_wstrb,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic [31:0]           cache_addr,
  input  logic                  cache_hit,
  input  logic [31:0]           cache_rdata,
  output logic [31:0]           cache_wdata,
  output logic                  cache_write_valid,
  output logic                  cache_write_access,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_we,
  output logic [31:0]           mem_req_addr,
  output logic [31:0]           mem_req_wdata,
  output logic [3:0]            mem_req_wstrb,
  input  logic                  mem_resp_valid,
  input  logic [31:0]           mem_resp_rdata,
  output logic [PERF_WIDTH-1:0] perf_hit_count,
  output logic [PERF_WIDTH-1:0] perf_miss_count
);

  localparam int OFFSET_BITS = $clog2(LINE_SIZE);

  // FSM state, kept as a plainly named register so checkers can bind to it.
  dcache_state_e state;
  dcache_state_e state_next;

  logic [31:0] addr_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;

  logic [31:0] line_addr;
  logic [31:0] merged_wdata;
  mem_req_t    mem_req;

  assign line_addr = {addr_q[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};

  // Store-hit merge: enabled bytes from the store, the rest from the line.
  always_comb begin
    merged_wdata = cache_rdata;
    for (int i = 0; i < DCACHE_WORD_BYTES; i++) begin
      if (wstrb_q[i]) merged_wdata[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  always_comb begin
    state_next        = state;
    req_ready         = 1'b0;
    resp_valid        = 1'b0;
    resp_rdata        = '0;
    cache_addr        = addr_q;
    cache_wdata       = '0;
    cache_write_valid = 1'b0;
    mem_req_valid     = 1'b0;
    mem_req           = '0;

    case (state)
      ST_IDLE: begin
        req_ready  = 1'b1;
        cache_addr = req_addr;
        if (req_valid) state_next = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (!we_q) begin
          if (cache_hit) begin
            resp_valid = 1'b1;
            resp_rdata = cache_rdata;
            state_next = ST_IDLE;
          end else begin
            state_next = ST_MISS_REQ;
          end
        end else begin
          // No write-allocate: only a hit touches the array.
          if (cache_hit) begin
            cache_write_valid = 1'b1;
            cache_wdata       = merged_wdata;
          end
          state_next = ST_WR_REQ;
        end
      end
      ST_MISS_REQ: begin
        mem_req_valid = 1'b1;
        mem_req.we    = 1'b0;
        mem_req.addr  = line_addr;
        mem_req.wstrb = 4'hF;
        if (mem_req_ready) state_next = ST_MISS_WAIT;
      end
      ST_MISS_WAIT: begin
        if (mem_resp_valid) begin
          // Refill and answer the load in the same cycle.
          cache_write_valid = 1'b1;
          cache_wdata       = mem_resp_rdata;
          resp_valid        = 1'b1;
          resp_rdata        = mem_resp_rdata;
          state_next        = ST_IDLE;
        end
      end
      ST_WR_REQ: begin
        mem_req_valid = 1'b1;
        mem_req.we    = 1'b1;
        mem_req.addr  = line_addr;
        mem_req.wdata = wdata_q;
        mem_req.wstrb = wstrb_q;
        if (mem_req_ready) state_next = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        if (mem_resp_valid) begin
          resp_valid = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // While reset is held every output is quiet; the array address still
    // tracks the LSU so the array sees a sensible index.
    if (rst) begin
      req_ready         = 1'b0;
      resp_valid        = 1'b0;
      resp_rdata        = '0;
      cache_addr        = req_addr;
      cache_wdata       = '0;
      cache_write_valid = 1'b0;
      mem_req_valid     = 1'b0;
      mem_req           = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state <= state_next;
      if (state == ST_IDLE && req_valid) begin
        addr_q  <= req_addr;
        we_q    <= req_we;
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
      end
    end
  end

  assign mem_req_we         = mem_req.we;
  assign mem_req_addr       = mem_req.addr;
  assign mem_req_wdata      = mem_req.wdata;
  assign mem_req_wstrb      = mem_req.wstrb;
  assign cache_write_access = 1'b0;

`ifdef DCACHE_PERF_EN
  logic lookup_fire;
  assign lookup_fire = (state == ST_LOOKUP);

  dcache_perf #(
    .PERF_WIDTH (PERF_WIDTH)
  ) u_perf (
    .clk        (clk),
    .rst        (rst),
    .lookup     (lookup_fire),
    .hit        (cache_hit),
    .hit_count  (perf_hit_count),
    .miss_count (perf_miss_count)
  );
`else
  assign perf_hit_count  = '0;
  assign perf_miss_count = '0;
`endif

endmodule
